ttc3_dus_loader: RTL
====================

# ttc3_dus_loader

Provisioning front-end for the Device Unique Secret. It accepts the DUS as a stream of 32-bit words over a valid/ready handshake and assembles them into one `DUS_WIDTH`-bit value. It then issues the single write pulse into the write-once DUS storage directly downstream, and confirms the commit by watching that storage's `dus_valid` flag. The assembly buffer is zeroised after every commit, abort or error.

## Interface
- `DUS_WIDTH`, 256, secret width; must be a multiple of `WORD_WIDTH`.
- `WORD_WIDTH`, 32, ingress word width; `NUM_WORDS = DUS_WIDTH/WORD_WIDTH` (8 by default).
- `VALID_TIMEOUT`, 4, cycles to wait for `dus_valid` after the write pulse.

Ports:
- `clock`  in  1  single clock domain, rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `load_start`  in  1  one-cycle request to begin a provisioning sequence.
- `abort`  in  1  cancels any sequence; has priority over everything except reset.
- `in_valid`  in  1  ingress word valid.
- `in_ready`  out  1  ingress word ready.
- `in_data`  in  `WORD_WIDTH`  ingress word.
- `dus_write_enable`  out  1  write strobe to DUS storage.
- `dus_write_data`  out  `DUS_WIDTH`  assembled secret; zero whenever `dus_write_enable`=0.
- `dus_valid`  in  1  storage's locked/valid flag.
- `busy`  out  1  sequence in progress.
- `load_done`  out  1  sticky success flag.
- `load_error`  out  1  sticky failure flag.
- `err_code`  out  2  00 none, 01 storage already locked, 10 checksum mismatch, 11 commit timeout.

## Operation
- FSM states: IDLE, COLLECT, WRITE, WAIT_VALID, DONE, ERROR.
- Outputs are decoded from the state register (Moore).
- IDLE: on `load_start`:
  - if `dus_valid`=1, go to ERROR with code 01;
  - otherwise clear the word counter and buffer, then go to COLLECT.
- COLLECT: `in_ready`=1. A word is accepted on `in_valid && in_ready`.
  - Word k (0-based) lands in bits `[k*WORD_WIDTH +: WORD_WIDTH]`, so the first word is the LSBs.
  - Counter width is `$clog2(NUM_WORDS+1)`. It never wraps; when the final word is accepted, go to WRITE.
- WRITE: `dus_write_enable`=1 with `dus_write_data`=buffer for exactly one cycle, then go to WAIT_VALID.
  - The buffer is zeroed on leaving WRITE.
- WAIT_VALID: when `dus_valid`=1, go to DONE. After `VALID_TIMEOUT` cycles without it, go to ERROR with code 11.
- DONE: `load_done`=1 (sticky). A new `load_start` behaves as in IDLE, so it yields code 01 because storage is locked.
- ERROR: `load_error`=1 and `err_code` are held. `load_start` restarts exactly as from IDLE, clearing error/code on entry to COLLECT.
- `abort` in any state: next state IDLE, buffer zeroed, counter cleared, done/error/code cleared.
  - A write pulse already being driven in WRITE completes; no further pulse is issued.
- `load_start` while `busy` is ignored.
- `busy`=1 in COLLECT, WRITE and WAIT_VALID.

## Timing
- Reset values: state IDLE, buffer/counter 0, `in_ready`=0, `dus_write_enable`=0, `dus_write_data`=0, `busy`=0, `load_done`=0, `load_error`=0, `err_code`=00.
- With `load_start` at edge 0, `in_ready` is high from cycle 1.
- With back-to-back words in cycles 1..8, WRITE occurs in cycle 9.
- Storage asserts `dus_valid` by cycle 10; `load_done` is high in cycle 11.
- Ingress stalls (`in_valid`=0) extend COLLECT indefinitely with no timeout.
- The timeout counter starts at 0 on entry to WAIT_VALID. It errors on the cycle it reaches `VALID_TIMEOUT` with `dus_valid` still 0.

## Configuration
- Macro: `TTC3_DUS_LOADER_CHECKSUM_EN`.
- Defined: COLLECT accepts `NUM_WORDS+1` words. The extra word must equal the XOR of all data words.
  - On a mismatch, go to ERROR with code 10; no write pulse is issued and the buffer is zeroed.
  - On a match, go to WRITE the next cycle. Latency grows by one cycle.
- Undefined: exactly `NUM_WORDS` words are accepted and code 10 is never produced.

## Structure
- Shared package `ttc3_pkg`: FSM state enum, `err_code` enum (`ERR_NONE`, `ERR_LOCKED`, `ERR_CHECKSUM`, `ERR_TIMEOUT`), default `DUS_WIDTH`/`WORD_WIDTH` constants.
- Sub-module `ttc3_dus_checksum` (running XOR accumulator with clear/accumulate/compare), instantiated only under the macro.

## Test plan
- Reset, then `load_start`, then 8 words 0x00000000..0x00000007 -> exactly one `dus_write_enable` cycle with data 0x00000007_00000006_..._00000000; `load_done`=1, `err_code`=00, `dus_write_data`=0 afterwards.
- After a successful load, `load_start` again -> `load_error`=1, `err_code`=01, no write pulse.
- Abort after 3 words, then a fresh 8-word load of 0xA5A5A5A5 -> written value is all 0xA5; no stale words are present.
- Tie `dus_valid` low after the write -> `load_error`=1 and `err_code`=11 exactly 4 cycles after WRITE.
- With the macro defined, 8 words 0x1..0x8 followed by checksum 0x00000008 -> write occurs. The same words with checksum 0x0 -> `err_code`=10, no write.
- Assert `reset_n`=0 during COLLECT -> all outputs return to reset values on the next edge; no write pulse.

Source files
------------

// File: rtl/ttc3_pkg.sv
// Shared types and defaults for the TTC3 DUS provisioning loader.
// Optional checksum word support is selected by TTC3_DUS_LOADER_CHECKSUM_EN.
package ttc3_pkg;

  localparam int DEFAULT_DUS_WIDTH  = 256;
  localparam int DEFAULT_WORD_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_COLLECT    = 3'd1,
    ST_WRITE      = 3'd2,
    ST_WAIT_VALID = 3'd3,
    ST_DONE       = 3'd4,
    ST_ERROR      = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_LOCKED   = 2'b01,
    ERR_CHECKSUM = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } err_code_e;

endpackage

// File: rtl/ttc3_dus_checksum.sv
// Running XOR accumulator over the DUS data words; compares against the trailer word.
// Only instantiated when TTC3_DUS_LOADER_CHECKSUM_EN is defined.
module ttc3_dus_checksum #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  accumulate,
  input  logic [WORD_WIDTH-1:0] data_in,
  input  logic [WORD_WIDTH-1:0] compare_word,
  output logic                  match
);

  logic [WORD_WIDTH-1:0] acc_q;
  logic [WORD_WIDTH-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (accumulate) begin
      acc_d = acc_q ^ data_in;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign match = (acc_q == compare_word);

endmodule

// File: rtl/ttc3_dus_loader.sv
// DUS provisioning front-end: assembles ingress words, issues one write pulse, confirms lock.
// Define TTC3_DUS_LOADER_CHECKSUM_EN to require a trailing XOR checksum word.
module ttc3_dus_loader
  import ttc3_pkg::*;
#(
  parameter int DUS_WIDTH     = DEFAULT_DUS_WIDTH,
  parameter int WORD_WIDTH    = DEFAULT_WORD_WIDTH,
  parameter int VALID_TIMEOUT = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  load_start,
  input  logic                  abort,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_data,
  output logic                  dus_write_enable,
  output logic [DUS_WIDTH-1:0]  dus_write_data,
  input  logic                  dus_valid,
  output logic                  busy,
  output logic                  load_done,
  output logic                  load_error,
  output logic [1:0]            err_code
);

  localparam int NUM_WORDS = DUS_WIDTH / WORD_WIDTH;
  localparam int CNT_W     = $clog2(NUM_WORDS + 1);
  localparam int TMO_W     = $clog2(VALID_TIMEOUT + 1);

  state_e               state_q, state_d;
  err_code_e            err_q, err_d;
  logic [DUS_WIDTH-1:0] buf_q, buf_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 idle_like;

  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR);

`ifdef TTC3_DUS_LOADER_CHECKSUM_EN
  logic cs_match;
  logic cs_clear;
  logic cs_accumulate;

  assign cs_clear      = abort || (state_q != ST_COLLECT);
  assign cs_accumulate = (state_q == ST_COLLECT) && in_valid && (cnt_q != CNT_W'(NUM_WORDS));

  ttc3_dus_checksum #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_checksum (
    .clock        (clock),
    .reset_n      (reset_n),
    .clear        (cs_clear),
    .accumulate   (cs_accumulate),
    .data_in      (in_data),
    .compare_word (in_data),
    .match        (cs_match)
  );
`endif

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (load_start) begin
          if (dus_valid) begin
            state_d = ST_ERROR;
            err_d   = ERR_LOCKED;
          end else begin
            state_d = ST_COLLECT;
            err_d   = ERR_NONE;
            buf_d   = '0;
            cnt_d   = '0;
          end
        end
      end

      ST_COLLECT: begin
        if (in_valid) begin
`ifdef TTC3_DUS_LOADER_CHECKSUM_EN
          // The trailer word is compared against the running XOR, never stored
          if (cnt_q == CNT_W'(NUM_WORDS)) begin
            if (cs_match) begin
              state_d = ST_WRITE;
            end else begin
              state_d = ST_ERROR;
              err_d   = ERR_CHECKSUM;
              buf_d   = '0;
            end
          end else begin
            for (int k = 0; k < NUM_WORDS; k++) begin
              if (cnt_q == CNT_W'(k)) begin
                buf_d[k*WORD_WIDTH +: WORD_WIDTH] = in_data;
              end
            end
            cnt_d = cnt_q + 1'b1;
          end
`else
          for (int k = 0; k < NUM_WORDS; k++) begin
            if (cnt_q == CNT_W'(k)) begin
              buf_d[k*WORD_WIDTH +: WORD_WIDTH] = in_data;
            end
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(NUM_WORDS - 1)) begin
            state_d = ST_WRITE;
          end
`endif
        end
      end

      ST_WRITE: begin
        state_d = ST_WAIT_VALID;
        buf_d   = '0;
        tmo_d   = '0;
      end

      ST_WAIT_VALID: begin
        tmo_d = tmo_q + 1'b1;
        if (dus_valid) begin
          state_d = ST_DONE;
        end else if (tmo_d == TMO_W'(VALID_TIMEOUT)) begin
          state_d = ST_ERROR;
          err_d   = ERR_TIMEOUT;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort wins over every transition; a pulse already on the wire simply ends
    if (abort) begin
      state_d = ST_IDLE;
      err_d   = ERR_NONE;
      buf_d   = '0;
      cnt_d   = '0;
      tmo_d   = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      err_q   <= ERR_NONE;
      buf_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  assign in_ready         = (state_q == ST_COLLECT);
  assign dus_write_enable = (state_q == ST_WRITE);
  assign dus_write_data   = dus_write_enable ? buf_q : '0;
  assign busy             = (state_q == ST_COLLECT) || (state_q == ST_WRITE) ||
                            (state_q == ST_WAIT_VALID);
  assign load_done        = (state_q == ST_DONE);
  assign load_error       = (state_q == ST_ERROR);
  assign err_code         = err_q;

endmodule
